reg_file_mp: RTL and testbench



---
 rtl/reg_file_mp.sv | 174 +++++++++++++++++
 tb/tb_reg_file_mp.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
//
// Purpose:
//   Parametrised integer register file for the pipelined OTTER core.
//   Register 0 is hardwired to zero. Reads are combinational on NUM_RD
//   independent ports; writes happen on the rising edge of CLK. A sequenced
//   bulk-clear engine zeroes registers 1..NREGS-1, one per cycle, so that a
//   context reset does not need the global reset. While a sweep runs the
//   write port is closed (WR_RDY low) and writeback must hold its request.
//
// Parameters:
//   XLEN    data width of each register
//   NREGS   number of registers (power of two, >= 4)
//   NUM_RD  number of read ports (1..4)
//   AW      address width, derived from NREGS
//
// Ports:
//   CLK     system clock, rising edge
//   RST_N   asynchronous active-low reset (clears every register)
//   WE      write enable
//   WA      write address
//   WD      write data
//   WR_RDY  write port accepting; low during a clear sweep
//   ADR     packed read addresses, port k at [k*AW +: AW]
//   RS      packed read data, port k at [k*XLEN +: XLEN]
//   CLR     single-cycle request to start a bulk clear
//   BUSY    clear sweep in progress
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a write accepted in the current cycle
//                      is forwarded to any read port addressing the same
//                      register. When undefined, reads show stored contents
//                      only and the hazard unit must stall one cycle.
// ---------------------------------------------------------------------------
module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   WE,
  input  logic [AW-1:0]          WA,
  input  logic [XLEN-1:0]        WD,
  output logic                   WR_RDY,
  input  logic [NUM_RD*AW-1:0]   ADR,
  output logic [NUM_RD*XLEN-1:0] RS,
  input  logic                   CLR,
  output logic                   BUSY
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // Last register visited by the sweep; reaching it ends the sweep, so the
  // pointer never has to wrap.
  localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

  state_t            state_q;
  state_t            state_d;
  logic [AW-1:0]     ptr_q;
  logic [AW-1:0]     ptr_d;
  logic              wr_en;
  logic [XLEN-1:0]   regs [NREGS];

  // Clear FSM state and sweep pointer. Reset aborts any sweep in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state and handshake outputs. The sweep starts at register 1
  // because register 0 is already permanently zero; it therefore lasts
  // NREGS-1 cycles. CLR arriving mid-sweep is ignored.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    BUSY    = 1'b0;
    WR_RDY  = 1'b1;
    case (state_q)
      IDLE: begin
        if (CLR) begin
          state_d = SWEEP;
          ptr_d   = AW'(1);
        end
      end
      SWEEP: begin
        BUSY   = 1'b1;
        WR_RDY = 1'b0;
        if (ptr_q == LAST_REG) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
    endcase
  end

  // A write commits only while the port is open and never to register 0.
  // RST_N is included so that the forwarding path stays quiet in reset.
  assign wr_en = WE && WR_RDY && (WA != '0) && RST_N;

  // Storage. In IDLE with CLR and a write on the same edge the write lands
  // first; the sweep that follows clears it again. During a sweep the
  // write port is closed, so the two branches never compete.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (state_q == SWEEP) begin
      regs[ptr_q] <= '0;
    end else if (wr_en) begin
      regs[WA] <= WD;
    end
  end

  // Read ports: a plain array lookup per lane, with address 0 forced to
  // zero last so that it wins over forwarding as well.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   rd_adr;
    logic [XLEN-1:0] rd_dat;

    assign rd_adr = ADR[k*AW +: AW];

    always_comb begin
      rd_dat = regs[rd_adr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (rd_adr == WA)) begin
        rd_dat = WD;
      end
`endif
      if (rd_adr == '0) begin
        rd_dat = '0;
      end
    end

    assign RS[k*XLEN +: XLEN] = rd_dat;
  end

`ifndef SYNTHESIS
  // Addresses must be known whenever the block is out of reset.
  property p_addr_known;
    @(posedge CLK) disable iff (!RST_N) !$isunknown({ADR, WA});
  endproperty
  a_addr_known: assert property (p_addr_known)
    else $error("reg_file_mp: unknown read or write address");

  // Writeback is expected to hold a refused write; report it once per
  // stall rather than every cycle it is held.
  logic drop_prev;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      drop_prev <= 1'b0;
    end else begin
      drop_prev <= WE && !WR_RDY;
      if (WE && !WR_RDY && !drop_prev) begin
        $warning("reg_file_mp: write to x%0d held off while clear sweep active", WA);
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
//
// Self-checking bench for reg_file_mp with three read ports. A behavioural
// model (array of register values plus a count of sweep cycles remaining)
// predicts every read and handshake output. Build with REGFILE_BYPASS_EN
// defined to exercise the forwarding variant; the model follows suit.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 3;
  localparam int AW     = 5;

  logic                   clk  = 1'b0;
  logic                   rstN = 1'b0;
  logic                   we   = 1'b0;
  logic [AW-1:0]          wa   = '0;
  logic [XLEN-1:0]        wd   = '0;
  logic                   wrRdy;
  logic [NUM_RD*AW-1:0]   adr  = '0;
  logic [NUM_RD*XLEN-1:0] rs;
  logic                   clr  = 1'b0;
  logic                   busy;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: register contents and how many sweep cycles remain.
  logic [XLEN-1:0] mRegs [NREGS];
  int              sweepLeft = 0;

  reg_file_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NUM_RD(NUM_RD)
  ) dut (
    .CLK   (clk),
    .RST_N (rstN),
    .WE    (we),
    .WA    (wa),
    .WD    (wd),
    .WR_RDY(wrRdy),
    .ADR   (adr),
    .RS    (rs),
    .CLR   (clr),
    .BUSY  (busy)
  );

  always #5 clk = ~clk;

  // Clear the model, matching what an asynchronous reset does.
  task automatic modelReset();
    for (int i = 0; i < NREGS; i++) mRegs[i] = '0;
    sweepLeft = 0;
  endtask

  // Value the model expects on a read port addressing register a, given the
  // inputs currently driven.
  function automatic logic [XLEN-1:0] expRead(input int a);
    logic [XLEN-1:0] v;
    v = (a == 0) ? '0 : mRegs[a];
`ifdef REGFILE_BYPASS_EN
    if (we && sweepLeft == 0 && wa != 0 && int'(wa) == a) v = wd;
`endif
    return v;
  endfunction

  function automatic logic [XLEN-1:0] lane(input int k);
    return rs[k*XLEN +: XLEN];
  endfunction

  task automatic setLane(input int k, input int a);
    adr[k*AW +: AW] = AW'(a);
  endtask

  // Advance one rising edge and apply the register file's rules to the
  // model: a sweep clears registers 1..NREGS-1 in order and refuses writes;
  // otherwise a write lands (never at 0) and CLR starts a fresh sweep.
  task automatic step();
    logic          doWrite;
    logic          doClr;
    logic [AW-1:0] a;
    logic [XLEN-1:0] d;
    doWrite = we && (wa != 0);
    doClr   = clr;
    a       = wa;
    d       = wd;
    @(posedge clk);
    if (sweepLeft == 0) begin
      if (doWrite) mRegs[a] = d;
      if (doClr) sweepLeft = NREGS - 1;
    end else begin
      mRegs[NREGS - sweepLeft] = '0;
      sweepLeft--;
    end
    #1;
  endtask

  task automatic writeReg(input int a, input logic [XLEN-1:0] d);
    we = 1'b1;
    wa = AW'(a);
    wd = d;
    step();
    we = 1'b0;
  endtask

  task automatic test_reset();
    modelReset();
    #2;
    compared++;
    if (busy !== 1'b0 || wrRdy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_handshake: busy=%b wrRdy=%b expected busy=0 wrRdy=1", busy, wrRdy);
    end
    for (int k = 0; k < NUM_RD; k++) begin
      compared++;
      if (lane(k) !== '0) begin
        mismatched++;
        $display("[TB] FAIL reset_lane%0d: got %h expected 00000000", k, lane(k));
      end
    end
    #10 rstN = 1'b1;
    writeReg(5, 32'hDEADBEEF);
    setLane(0, 5);
    #1;
    compared++;
    if (lane(0) !== expRead(5)) begin
      mismatched++;
      $display("[TB] FAIL reset_prewrite: got %h expected %h", lane(0), expRead(5));
    end
    // Pull reset mid-cycle, no clock edge involved.
    #2 rstN = 1'b0;
    modelReset();
    #1;
    compared++;
    if (lane(0) !== 32'h0 || busy !== 1'b0 || wrRdy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_async: rs=%h busy=%b wrRdy=%b expected rs=0 busy=0 wrRdy=1",
               lane(0), busy, wrRdy);
    end
    @(negedge clk);
    rstN = 1'b1;
    #1;
  endtask

  task automatic test_write_read();
    writeReg(3, 32'h12345678);
    writeReg(7, 32'hCAFEF00D);
    setLane(0, 3);
    setLane(1, 7);
    setLane(2, 0);
    #1;
    for (int k = 0; k < NUM_RD; k++) begin
      compared++;
      if (lane(k) !== expRead(int'(adr[k*AW +: AW]))) begin
        mismatched++;
        $display("[TB] FAIL wr_lane%0d: got %h expected %h", k, lane(k),
                 expRead(int'(adr[k*AW +: AW])));
      end
    end
    writeReg(0, 32'hFFFFFFFF);
    #1;
    compared++;
    if (lane(2) !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL wr_zero_reg: got %h expected 00000000", lane(2));
    end
  endtask

  task automatic test_bypass();
    writeReg(9, 32'h11111111);
    we = 1'b1;
    wa = AW'(9);
    wd = 32'hA5A5A5A5;
    setLane(0, 9);
    setLane(1, 0);
    #1;
    compared++;
    if (lane(0) !== expRead(9)) begin
      mismatched++;
      $display("[TB] FAIL bypass_before_edge: got %h expected %h", lane(0), expRead(9));
    end
    step();
    we = 1'b0;
    #1;
    compared++;
    if (lane(0) !== expRead(9) || lane(0) !== 32'hA5A5A5A5) begin
      mismatched++;
      $display("[TB] FAIL bypass_after_edge: got %h expected a5a5a5a5", lane(0));
    end
  endtask

  task automatic test_clear_sweep();
    int cnt;
    for (int i = 1; i < NREGS; i++) writeReg(i, XLEN'(i));
    setLane(0, 10);
    clr = 1'b1;
    step();
    clr = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      compared++;
      if (busy !== (sweepLeft != 0) || wrRdy !== (sweepLeft == 0)) begin
        mismatched++;
        $display("[TB] FAIL sweep_flags: busy=%b wrRdy=%b at cycle %0d", busy, wrRdy, cnt);
      end
      if (cnt == 5) begin
        compared++;
        if (lane(0) !== expRead(10) || lane(0) !== 32'd10) begin
          mismatched++;
          $display("[TB] FAIL sweep_mid_reg10: got %h expected %h", lane(0), expRead(10));
        end
      end
      step();
    end
    compared++;
    if (cnt != NREGS - 1) begin
      mismatched++;
      $display("[TB] FAIL sweep_length: got %0d cycles expected %0d", cnt, NREGS - 1);
    end
    for (int i = 0; i < NREGS; i++) begin
      setLane(0, i);
      #1;
      compared++;
      if (lane(0) !== 32'h0 || lane(0) !== expRead(i)) begin
        mismatched++;
        $display("[TB] FAIL sweep_cleared_x%0d: got %h expected 00000000", i, lane(0));
      end
    end
  endtask

  task automatic test_handshake();
    int cnt;
    writeReg(4, 32'h77);
    clr = 1'b1;
    step();
    clr = 1'b0;
    we  = 1'b1;
    wa  = AW'(4);
    wd  = 32'h55;
    setLane(0, 4);
    cnt = 0;
    while (wrRdy !== 1'b1 && cnt < 100) begin
      cnt++;
      clr = (cnt == 10);
      #1;
      compared++;
      if (lane(0) !== expRead(4) || busy !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL hs_during_sweep: rs=%h busy=%b expected rs=%h busy=1 at cycle %0d",
                 lane(0), busy, expRead(4), cnt);
      end
      step();
    end
    clr = 1'b0;
    compared++;
    if (cnt != NREGS - 1) begin
      mismatched++;
      $display("[TB] FAIL hs_sweep_length: got %0d cycles expected %0d", cnt, NREGS - 1);
    end
    compared++;
    if (lane(0) !== expRead(4)) begin
      mismatched++;
      $display("[TB] FAIL hs_held_read: got %h expected %h", lane(0), expRead(4));
    end
    step();
    we = 1'b0;
    #1;
    compared++;
    if (lane(0) !== 32'h55 || lane(0) !== expRead(4)) begin
      mismatched++;
      $display("[TB] FAIL hs_write_after_sweep: got %h expected 00000055", lane(0));
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cnt;
    for (int i = 1; i < NREGS; i++) writeReg(i, $urandom);
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int c = 1; c < 12; c++) step();
    #2 rstN = 1'b0;
    modelReset();
    #1;
    compared++;
    if (busy !== 1'b0 || wrRdy !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_flags: busy=%b wrRdy=%b expected busy=0 wrRdy=1", busy, wrRdy);
    end
    for (int i = 0; i < NREGS; i++) begin
      setLane(1, i);
      #1;
      compared++;
      if (lane(1) !== 32'h0) begin
        mismatched++;
        $display("[TB] FAIL rst_mid_x%0d: got %h expected 00000000", i, lane(1));
      end
    end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      step();
    end
    compared++;
    if (cnt != NREGS - 1) begin
      mismatched++;
      $display("[TB] FAIL rst_mid_resweep: got %0d cycles expected %0d", cnt, NREGS - 1);
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 300; it++) begin
      we = 1'($urandom_range(0, 1));
      wa = AW'($urandom_range(0, NREGS - 1));
      wd = $urandom;
      setLane(0, ($urandom_range(0, 1) == 1) ? int'(wa) : $urandom_range(0, NREGS - 1));
      setLane(1, $urandom_range(0, NREGS - 1));
      setLane(2, $urandom_range(0, 3));
      clr = ($urandom_range(0, 59) == 0);
      #1;
      for (int k = 0; k < NUM_RD; k++) begin
        compared++;
        if (lane(k) !== expRead(int'(adr[k*AW +: AW]))) begin
          mismatched++;
          $display("[TB] FAIL rand_lane%0d it%0d: got %h expected %h", k, it, lane(k),
                   expRead(int'(adr[k*AW +: AW])));
        end
      end
      compared++;
      if (busy !== (sweepLeft != 0) || wrRdy !== (sweepLeft == 0)) begin
        mismatched++;
        $display("[TB] FAIL rand_flags it%0d: busy=%b wrRdy=%b expected busy=%b", it, busy,
                 wrRdy, sweepLeft != 0);
      end
      step();
    end
    we  = 1'b0;
    clr = 1'b0;
    n = 0;
    while (sweepLeft != 0 && n < 100) begin
      n++;
      step();
    end
    for (int i = 0; i < NREGS; i++) begin
      setLane(0, i);
      #1;
      compared++;
      if (lane(0) !== expRead(i)) begin
        mismatched++;
        $display("[TB] FAIL rand_final_x%0d: got %h expected %h", i, lane(0), expRead(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear_sweep();
    test_handshake();
    test_reset_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
